// File: rtl/char_console_ctrl.sv
// Byte-stream to character-memory write sequencer with cursor, clear-screen and scroll-up.
// Optional scroll on last-row newline via CHARCON_SCROLL_EN; otherwise the cursor wraps to row 0.
module char_console_ctrl #(
    parameter int COLS = 80,
    parameter int ROWS = 30
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        char_valid_i,
    input  logic [7:0]  char_data_i,
    output logic        char_ready_o,
    input  logic        clear_i,
    input  logic [11:0] fg_color_i,
    input  logic [11:0] bg_color_i,
    output logic        mem_we_o,
    output logic [11:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    output logic [6:0]  cursor_col_o,
    output logic [4:0]  cursor_row_o,
    output logic        busy_o
);

    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_CLEAR
`ifdef CHARCON_SCROLL_EN
        , S_SCROLL_RD,
        S_SCROLL_WR,
        S_SCROLL_BLANK
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  col_q, col_d, scan_col_q, scan_col_d;
    logic [4:0]  row_q, row_d, scan_row_q, scan_row_d;
    logic [7:0]  char_q, char_d, ctl_q, ctl_d;
    logic        ctl_vld_q, ctl_vld_d;
    logic        clr_pend_q, clr_pend_d;
    logic        scroll_go;
    logic [31:0] blank_word;

`ifndef CHARCON_SCROLL_EN
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata_i;
`endif

    assign blank_word   = {bg_color_i, fg_color_i, 8'h20};
    assign cursor_col_o = col_q;
    assign cursor_row_o = row_q;
    assign busy_o       = (state_q != S_IDLE);

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        scan_col_d   = scan_col_q;
        scan_row_d   = scan_row_q;
        char_d       = char_q;
        ctl_d        = ctl_q;
        ctl_vld_d    = 1'b0;
        clr_pend_d   = clr_pend_q | clear_i;
        scroll_go    = 1'b0;
        char_ready_o = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;

        case (state_q)
            S_IDLE: begin
                // Control bytes take effect one edge after acceptance
                if (ctl_vld_q) begin
                    case (ctl_q)
                        8'h0A: begin
                            if (row_q == LAST_ROW) begin
`ifdef CHARCON_SCROLL_EN
                                scroll_go = 1'b1;
`else
                                row_d = '0;
`endif
                            end else begin
                                row_d = row_q + 5'd1;
                            end
                        end
                        8'h0D:   col_d = '0;
                        8'h08:   if (col_q != '0) col_d = col_q - 7'd1;
                        default: ;
                    endcase
                end
                if (scroll_go) begin
`ifdef CHARCON_SCROLL_EN
                    state_d    = S_SCROLL_RD;
                    scan_row_d = 5'd1;
                    scan_col_d = '0;
`endif
                end else if (clr_pend_q || clear_i) begin
                    state_d    = S_CLEAR;
                    scan_row_d = '0;
                    scan_col_d = '0;
                    clr_pend_d = 1'b0;
                end else begin
                    char_ready_o = 1'b1;
                    if (char_valid_i) begin
                        if (char_data_i >= 8'h20 && char_data_i <= 8'h7E) begin
                            char_d  = char_data_i;
                            state_d = S_WRITE;
                        end else begin
                            ctl_d     = char_data_i;
                            ctl_vld_d = 1'b1;
                        end
                    end
                end
            end
            S_WRITE: begin
                mem_we_o    = 1'b1;
                mem_addr_o  = {row_q, col_q};
                mem_wdata_o = {bg_color_i, fg_color_i, char_q};
                state_d     = S_IDLE;
                if (col_q == LAST_COL) begin
                    col_d = '0;
                    if (row_q == LAST_ROW) begin
`ifdef CHARCON_SCROLL_EN
                        state_d    = S_SCROLL_RD;
                        scan_row_d = 5'd1;
                        scan_col_d = '0;
`else
                        row_d = '0;
`endif
                    end else begin
                        row_d = row_q + 5'd1;
                    end
                end else begin
                    col_d = col_q + 7'd1;
                end
            end
            S_CLEAR: begin
                mem_we_o    = 1'b1;
                mem_addr_o  = {scan_row_q, scan_col_q};
                mem_wdata_o = blank_word;
                if (scan_col_q == LAST_COL) begin
                    scan_col_d = '0;
                    if (scan_row_q == LAST_ROW) begin
                        state_d = S_IDLE;
                        col_d   = '0;
                        row_d   = '0;
                    end else begin
                        scan_row_d = scan_row_q + 5'd1;
                    end
                end else begin
                    scan_col_d = scan_col_q + 7'd1;
                end
            end
`ifdef CHARCON_SCROLL_EN
            S_SCROLL_RD: begin
                mem_addr_o = {scan_row_q, scan_col_q};
                state_d    = S_SCROLL_WR;
            end
            S_SCROLL_WR: begin
                // Read data for the address presented last cycle lands one row up
                mem_we_o    = 1'b1;
                mem_addr_o  = {scan_row_q - 5'd1, scan_col_q};
                mem_wdata_o = mem_rdata_i;
                state_d     = S_SCROLL_RD;
                if (scan_col_q == LAST_COL) begin
                    scan_col_d = '0;
                    if (scan_row_q == LAST_ROW) begin
                        state_d = S_SCROLL_BLANK;
                    end else begin
                        scan_row_d = scan_row_q + 5'd1;
                    end
                end else begin
                    scan_col_d = scan_col_q + 7'd1;
                end
            end
            S_SCROLL_BLANK: begin
                mem_we_o    = 1'b1;
                mem_addr_o  = {LAST_ROW, scan_col_q};
                mem_wdata_o = blank_word;
                if (scan_col_q == LAST_COL) begin
                    state_d = S_IDLE;
                end else begin
                    scan_col_d = scan_col_q + 7'd1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            col_q      <= '0;
            row_q      <= '0;
            scan_col_q <= '0;
            scan_row_q <= '0;
            char_q     <= '0;
            ctl_q      <= '0;
            ctl_vld_q  <= 1'b0;
            clr_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            scan_col_q <= scan_col_d;
            scan_row_q <= scan_row_d;
            char_q     <= char_d;
            ctl_q      <= ctl_d;
            ctl_vld_q  <= ctl_vld_d;
            clr_pend_q <= clr_pend_d;
        end
    end

endmodule

// File: tb/tb_char_console_ctrl.sv
// Directed bench for char_console_ctrl (80x30) with a registered-read character memory model.
module tb_char_console_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [7:0]  data = 8'h00;
    logic        ready;
    logic        clear = 1'b0;
    logic [11:0] fg = 12'hFFF;
    logic [11:0] bg = 12'h00F;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] rdata_q = '0;
    logic [6:0]  ccol;
    logic [4:0]  crow;
    logic        busy;

    logic [31:0] mem [4096];
    logic        preload = 1'b0;
    int          wr_cnt = 0;
    int          bad_cnt = 0;
    logic [11:0] last_addr = '0;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    char_console_ctrl #(.COLS(80), .ROWS(30)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .char_valid_i(valid), .char_data_i(data), .char_ready_o(ready),
        .clear_i(clear), .fg_color_i(fg), .bg_color_i(bg),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(rdata_q),
        .cursor_col_o(ccol), .cursor_row_o(crow), .busy_o(busy)
    );

    always @(posedge clk) begin
        rdata_q <= mem[mem_addr];
        if (preload) begin
            for (int a = 0; a < 4096; a++) mem[a] <= 32'hC0DE0000 | 32'(a);
        end else if (rst_n && mem_we) begin
            mem[mem_addr] <= mem_wdata;
            wr_cnt        <= wr_cnt + 1;
            last_addr     <= mem_addr;
            if (mem_addr[6:0] >= 7'd80 || mem_addr[11:7] >= 5'd30) bad_cnt <= bad_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic put(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        valid = 1'b1;
        data  = b;
        #1;
        while (!ready && n < 10000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("put_ready", 32'(ready), 32'd1);
        @(negedge clk);
        valid = 1'b0;
        #1;
    endtask

    // Entered at the first busy cycle; returns at the first non-busy cycle
    task automatic count_busy(input int pulse_at, output int n, output int rviol);
        n = 0;
        rviol = 0;
        while (busy && n < 10000) begin
            n++;
            if (ready) rviol++;
            @(negedge clk);
            clear = (n == pulse_at);
            #1;
        end
        clear = 1'b0;
        chk("busy_end", 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic        vld;
        logic [7:0]  dat;
        logic        clr;
        logic [11:0] fg;
        logic [11:0] bg;
        logic        rdy;
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [6:0]  col;
        logic [4:0]  row;
        logic        busy;
    } vec_t;

    vec_t tbl [17];

    initial begin
        int n, rv, wr0, bad;
        logic [11:0] a;

        tbl[0]  = '{1'b0, 8'h00, 1'b0, 12'hFFF, 12'h00F, 1'b1, 1'b0, 12'h000, 32'h0,        7'd0, 5'd0, 1'b0};
        tbl[1]  = '{1'b1, 8'h48, 1'b0, 12'hFFF, 12'h00F, 1'b1, 1'b0, 12'h000, 32'h0,        7'd0, 5'd0, 1'b0};
        tbl[2]  = '{1'b1, 8'h69, 1'b0, 12'hFFF, 12'h00F, 1'b0, 1'b1, 12'h000, 32'h00FFFF48, 7'd0, 5'd0, 1'b1};
        tbl[3]  = '{1'b1, 8'h69, 1'b0, 12'hFFF, 12'h00F, 1'b1, 1'b0, 12'h000, 32'h0,        7'd1, 5'd0, 1'b0};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 12'hFFF, 12'h00F, 1'b0, 1'b1, 12'h001, 32'h00FFFF69, 7'd1, 5'd0, 1'b1};
        tbl[5]  = '{1'b1, 8'h0D, 1'b0, 12'hFFF, 12'h00F, 1'b1, 1'b0, 12'h000, 32'h0,        7'd2, 5'd0, 1'b0};
        tbl[6]  = '{1'b1, 8'h0A, 1'b0, 12'hFFF, 12'h00F, 1'b1, 1'b0, 12'h000, 32'h0,        7'd2, 5'd0, 1'b0};
        tbl[7]  = '{1'b1, 8'h08, 1'b0, 12'hFFF, 12'h00F, 1'b1, 1'b0, 12'h000, 32'h0,        7'd0, 5'd0, 1'b0};
        tbl[8]  = '{1'b1, 8'h08, 1'b0, 12'hFFF, 12'h00F, 1'b1, 1'b0, 12'h000, 32'h0,        7'd0, 5'd1, 1'b0};
        tbl[9]  = '{1'b1, 8'h41, 1'b0, 12'hFFF, 12'h00F, 1'b1, 1'b0, 12'h000, 32'h0,        7'd0, 5'd1, 1'b0};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 12'h123, 12'hABC, 1'b0, 1'b1, 12'h080, 32'hABC12341, 7'd0, 5'd1, 1'b1};
        tbl[11] = '{1'b1, 8'h1B, 1'b0, 12'hFFF, 12'h00F, 1'b1, 1'b0, 12'h000, 32'h0,        7'd1, 5'd1, 1'b0};
        tbl[12] = '{1'b1, 8'h08, 1'b0, 12'hFFF, 12'h00F, 1'b1, 1'b0, 12'h000, 32'h0,        7'd1, 5'd1, 1'b0};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 12'hFFF, 12'h00F, 1'b1, 1'b0, 12'h000, 32'h0,        7'd1, 5'd1, 1'b0};
        tbl[14] = '{1'b0, 8'h00, 1'b0, 12'hFFF, 12'h00F, 1'b1, 1'b0, 12'h000, 32'h0,        7'd0, 5'd1, 1'b0};
        tbl[15] = '{1'b1, 8'h5A, 1'b1, 12'hFFF, 12'h00F, 1'b0, 1'b0, 12'h000, 32'h0,        7'd0, 5'd1, 1'b0};
        tbl[16] = '{1'b1, 8'h5A, 1'b0, 12'hFFF, 12'h00F, 1'b0, 1'b1, 12'h000, 32'h00FFFF20, 7'd0, 5'd1, 1'b1};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            valid = tbl[i].vld;
            data  = tbl[i].dat;
            clear = tbl[i].clr;
            fg    = tbl[i].fg;
            bg    = tbl[i].bg;
            #1;
            chk($sformatf("v%0d.rdy", i),   32'(ready),     32'(tbl[i].rdy));
            chk($sformatf("v%0d.we", i),    32'(mem_we),    32'(tbl[i].we));
            chk($sformatf("v%0d.addr", i),  32'(mem_addr),  32'(tbl[i].addr));
            chk($sformatf("v%0d.wdata", i), mem_wdata,      tbl[i].wdata);
            chk($sformatf("v%0d.col", i),   32'(ccol),      32'(tbl[i].col));
            chk($sformatf("v%0d.row", i),   32'(crow),      32'(tbl[i].row));
            chk($sformatf("v%0d.busy", i),  32'(busy),      32'(tbl[i].busy));
        end
        clear = 1'b0;

        // Clear started by the last table vector; 'Z' held on char_valid throughout
        wr0 = wr_cnt;
        count_busy(-1, n, rv);
        chk("clr_cycles", 32'(n), 32'd2400);
        chk("clr_rdy_viol", 32'(rv), 32'd0);
        chk("clr_writes", 32'(wr_cnt - wr0), 32'd2400);
        chk("clr_cursor", 32'({crow, ccol}), 32'd0);
        chk("clr_rdy_after", 32'(ready), 32'd1);
        bad = 0;
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 80; c++) begin
                a = {5'(r), 7'(c)};
                if (mem[a] !== 32'h00FFFF20) bad++;
            end
        chk("clr_contents", 32'(bad), 32'd0);
        @(negedge clk);
        valid = 1'b0;
        #1;
        chk("z_we", 32'(mem_we), 32'd1);
        chk("z_addr", 32'(mem_addr), 32'h000);
        chk("z_wdata", mem_wdata, 32'h00FFFF5A);

        // 80 printables from the origin wrap to the next row
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wr0 = wr_cnt;
        for (int i = 0; i < 80; i++) put(8'h41 + 8'(i % 26));
        @(negedge clk);
        #1;
        chk("row_wr_cnt", 32'(wr_cnt - wr0), 32'd80);
        chk("row_last_addr", 32'(last_addr), 32'h04F);
        chk("row_cursor", 32'({crow, ccol}), 32'({5'd1, 7'd0}));

        put(8'h0D);
        for (int i = 0; i < 28; i++) put(8'h0A);
        for (int i = 0; i < 5; i++) put(8'h2E);
        @(negedge clk);
        #1;
        chk("pos_cursor", 32'({crow, ccol}), 32'({5'd29, 7'd5}));

        @(negedge clk);
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;

`ifdef CHARCON_SCROLL_EN
        @(negedge clk);
        valid = 1'b1;
        data  = 8'h0A;
        #1;
        chk("lf_rdy", 32'(ready), 32'd1);
        @(negedge clk);
        data = 8'h51;
        #1;
        chk("lf_pend_rdy", 32'(ready), 32'd0);
        chk("lf_pend_busy", 32'(busy), 32'd0);
        @(negedge clk);
        #1;
        count_busy(100, n, rv);
        chk("scr_cycles", 32'(n), 32'd4720);
        chk("scr_rdy_viol", 32'(rv), 32'd0);
        chk("scr_cursor", 32'({crow, ccol}), 32'({5'd29, 7'd5}));
        chk("scr_pend_rdy", 32'(ready), 32'd0);
        bad = 0;
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 80; c++) begin
                a = {5'(r), 7'(c)};
                if (r < 29) begin
                    if (mem[a] !== (32'hC0DE0000 | 32'({5'(r + 1), 7'(c)}))) bad++;
                end else if (mem[a] !== 32'h00FFFF20) bad++;
            end
        if (mem[12'h050] !== 32'hC0DE0050) bad++;
        chk("scr_contents", 32'(bad), 32'd0);
`else
        put(8'h0A);
        chk("wrap_busy0", 32'(busy), 32'd0);
        @(negedge clk);
        #1;
        chk("wrap_busy1", 32'(busy), 32'd0);
        chk("wrap_cursor", 32'({crow, ccol}), 32'({5'd0, 7'd5}));
        chk("wrap_no_blank", mem[12'h005], 32'hC0DE0005);
        @(negedge clk);
        clear = 1'b1;
        valid = 1'b1;
        data  = 8'h51;
        #1;
        chk("clr_prio_rdy", 32'(ready), 32'd0);
        @(negedge clk);
        clear = 1'b0;
        #1;
        count_busy(50, n, rv);
        chk("clr1_cycles", 32'(n), 32'd2400);
        chk("clr1_rdy_viol", 32'(rv), 32'd0);
        chk("clr1_pend_rdy", 32'(ready), 32'd0);
`endif
        // Pending clear runs next with 'Q' still offered
        @(negedge clk);
        #1;
        count_busy(-1, n, rv);
        chk("clr2_cycles", 32'(n), 32'd2400);
        chk("clr2_rdy_viol", 32'(rv), 32'd0);
        chk("clr2_rdy_after", 32'(ready), 32'd1);
        chk("clr2_cursor", 32'({crow, ccol}), 32'd0);
        @(negedge clk);
        valid = 1'b0;
        #1;
        chk("q_we", 32'(mem_we), 32'd1);
        chk("q_addr", 32'(mem_addr), 32'h000);
        chk("q_wdata", mem_wdata, 32'h00FFFF51);

        // Reset in the middle of a clear
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (50) @(negedge clk);
        #1;
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_cursor", 32'({crow, ccol}), 32'({5'd0, 7'd1}));
        rst_n = 1'b0;
        #1;
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_cursor", 32'({crow, ccol}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdy", 32'(ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        put(8'h41);
        chk("a_we", 32'(mem_we), 32'd1);
        chk("a_addr", 32'(mem_addr), 32'h000);
        chk("a_wdata", mem_wdata, 32'h00FFFF41);

        @(negedge clk);
        chk("out_of_range_writes", 32'(bad_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/char_console_ctrl.md
# char_console_ctrl

Sequencing controller for the character/color memory's data-side write port. Accepts a stream of ASCII bytes from a requester over a valid/ready handshake, maintains a text cursor, and converts the stream into single-word memory writes. It also runs the multi-cycle clear-screen and scroll-up sequences, so software and the UART bridge only emit bytes. It sits between the I/O bus and the data port of the VGA character generator.

## Interface

- COLS, 80: visible columns; 1..128.
- ROWS, 30: visible rows; 2..32.
- clk  in  1  data-side clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- char_valid  in  1  byte offered.
- char_data  in  8  ASCII byte.
- char_ready  out  1  byte accepted when char_valid && char_ready.
- clear  in  1  single-cycle request to clear the screen.
- fg_color  in  12  foreground applied to subsequent writes.
- bg_color  in  12  background applied to subsequent writes.
- mem_we  out  1  write strobe to the character memory data port.
- mem_addr  out  12  {row[4:0], col[6:0]}.
- mem_wdata  out  32  {bg[11:0], fg[11:0], char[7:0]}; bits [31:20] are the background, [19:8] the foreground.
- mem_rdata  in  32  read data for mem_addr, valid one cycle after the address is presented.
- cursor_col  out  7  current column.
- cursor_row  out  5  current row.
- busy  out  1  high in any state other than IDLE.

## Operation

- Blank word: {bg_color, fg_color, 8'h20}. Colors are sampled each cycle they are used.
- States: IDLE, WRITE, CLEAR, SCROLL_RD, SCROLL_WR, SCROLL_BLANK.
- IDLE: char_ready=1. A pending clear takes priority over char_valid; in that cycle char_ready=0.
- Accepted byte decode:
  - 0x20–0x7E: go to WRITE. Write {bg,fg,byte} at the cursor, then advance col. At col==COLS-1, advance sets col=0 and performs a newline.
  - 0x0A (newline): row+1. On row==ROWS-1, row is held and SCROLL_RD is entered.
  - 0x0D: col=0.
  - 0x08: col-1 if col>0; no erase.
  - All other bytes are consumed with no effect.
- CLEAR: writes the blank word to every (row<ROWS, col<COLS), row-major, one write per cycle. Ends with cursor=(0,0) and returns to IDLE.
- SCROLL: for r=1..ROWS-1 and c=0..COLS-1:
  - SCROLL_RD presents {r,c} with mem_we=0.
  - SCROLL_WR writes mem_rdata to {r-1,c}.
  - SCROLL_BLANK then writes the blank word to row ROWS-1, cols 0..COLS-1.
  - Cursor ends at (ROWS-1, 0), or (ROWS-1, col) for a bare 0x0A.
- A clear pulse outside IDLE sets a pending flag. The flag is serviced on the next IDLE cycle and cleared when CLEAR is entered.
- Columns COLS..127 and rows ROWS..31 are never written.

## Timing

- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, cursor=(0,0), busy=0, char_ready=1, clear pending=0, state=IDLE.
- Printable byte accepted at edge N:
  - Cycle N→N+1: mem_we=1 with address = cursor before advance.
  - Cursor updates at edge N+1.
  - char_ready=1 again from N+1 unless a scroll is triggered.
- Control bytes (0x0A without scroll, 0x0D, 0x08, others): cursor updates at edge N+1, and char_ready stays 1. Throughput is 1 byte/cycle.
- CLEAR: exactly ROWS×COLS write cycles; 2400 at default.
- SCROLL: 2×COLS×(ROWS-1) + COLS cycles; 4720 at default.
- busy is asserted in the first cycle after the transition out of IDLE. It deasserts in the cycle IDLE is re-entered.
- rst_n low mid-sequence: immediate return to reset values. Memory is left partially updated and there is no completion.

## Configuration

- CHARCON_SCROLL_EN defined: newline on the last row scrolls, as described above.
- CHARCON_SCROLL_EN undefined:
  - SCROLL states and the mem_rdata path are removed.
  - A newline on the last row wraps to row 0; that row is not blanked.
  - mem_rdata is unused.

## Test plan

- Reset, then bytes 'H','i' with fg=0xFFF, bg=0x00F: writes addr 0x000 data 0x00FFFF48, then addr 0x001 data 0x00FFFF69; cursor=(0,2).
- 80 printable bytes from (0,0): last write at addr 0x04F; cursor=(1,0).
- clear pulse in IDLE: 2400 consecutive writes covering addr 0x000–0x04F … 0xE80–0xECF, each with blank word; busy high 2400 cycles; cursor=(0,0).
- Preload memory, cursor at (29,5), send 0x0A (SCROLL_EN): {1,c}→{0,c} … {29,c}→{28,c} copied; row 29 blanked; 4720 busy cycles; cursor=(29,5).
- clear asserted mid-scroll: scroll completes; CLEAR starts on the next IDLE cycle; char_valid held high is not accepted until CLEAR ends.
- rst_n pulsed low during CLEAR: mem_we=0 and cursor=(0,0) immediately; next byte 'A' writes at addr 0x000.
